// File: rtl/adpcm_dec_mc.sv
// Multi-channel IMA ADPCM decoder: one 4-bit code per cycle, per-channel predictor/index state,
// header preloads, and a single registered output stage with valid/ready backpressure.
module adpcm_dec_mc #(
    parameter int NUM_CH = 2,
    parameter int OUT_W  = 16,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_code,
    input  logic [CH_W-1:0]   in_ch,
    input  logic              in_sop,
    input  logic              in_eop,
    input  logic              hdr_valid,
    input  logic [CH_W-1:0]   hdr_ch,
    input  logic [15:0]       hdr_pred,
    input  logic [6:0]        hdr_index,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_sample,
    output logic [CH_W-1:0]   out_ch,
    output logic              out_eop
);

    localparam logic [CH_W:0] CH_LIMIT = NUM_CH[CH_W:0];

    localparam int STEP [89] = '{
        7, 8, 9, 10, 11, 12, 13, 14, 16, 17,
        19, 21, 23, 25, 28, 31, 34, 37, 41, 45,
        50, 55, 60, 66, 73, 80, 88, 97, 107, 118,
        130, 143, 157, 173, 190, 209, 230, 253, 279, 307,
        337, 371, 408, 449, 494, 544, 598, 658, 724, 796,
        876, 963, 1060, 1166, 1282, 1411, 1552, 1707, 1878, 2066,
        2272, 2499, 2749, 3024, 3327, 3660, 4026, 4428, 4871, 5358,
        5894, 6484, 7132, 7845, 8630, 9493, 10442, 11487, 12635, 13899,
        15289, 16818, 18500, 20350, 22385, 24623, 27086, 29794, 32767
    };

    logic signed [OUT_W-1:0] pred_q [NUM_CH];
    logic [6:0]              index_q [NUM_CH];

    logic                    accept;
    logic                    ch_ok;
    logic                    hdr_ok;
    logic                    hdr_hit;
    logic [CH_W-1:0]         ch_sel;
    logic [6:0]              hdr_idx_c;
    logic signed [OUT_W-1:0] hdr_pred_x;
    logic signed [OUT_W-1:0] pe;
    logic [6:0]              ie;
    logic [14:0]             step;
    logic [16:0]             diff;
    logic signed [OUT_W+1:0] pe_x;
    logic signed [OUT_W+1:0] diff_x;
    logic signed [OUT_W+1:0] sum;
    logic                    ovf;
    logic signed [OUT_W-1:0] new_pred;
    logic signed [7:0]       idx_adj;
    logic signed [7:0]       idx_sum;
    logic [6:0]              new_idx;

    assign in_ready   = !out_valid || out_ready;
    assign accept     = in_valid && in_ready;
    assign ch_ok      = {1'b0, in_ch} < CH_LIMIT;
    assign hdr_ok     = {1'b0, hdr_ch} < CH_LIMIT;
    assign ch_sel     = ch_ok ? in_ch : '0;
    assign hdr_hit    = hdr_valid && hdr_ok && (hdr_ch == in_ch);
    assign hdr_idx_c  = (hdr_index > 7'd88) ? 7'd88 : hdr_index;
    assign hdr_pred_x = (OUT_W)'($signed(hdr_pred));

    // A coincident header wins over sop, which wins over the stored channel state.
    always_comb begin
        pe = pred_q[ch_sel];
        ie = index_q[ch_sel];
        if (hdr_hit) begin
            pe = hdr_pred_x;
            ie = hdr_idx_c;
        end else if (in_sop) begin
            pe = '0;
            ie = '0;
        end
    end

    always_comb begin
        step = STEP[ie][14:0];
        diff = {5'd0, step[14:3]};
        if (in_code[2]) diff = diff + {2'd0, step};
        if (in_code[1]) diff = diff + {3'd0, step[14:1]};
        if (in_code[0]) diff = diff + {4'd0, step[14:2]};

        pe_x   = (OUT_W+2)'(pe);
        diff_x = (OUT_W+2)'(diff);
        sum    = in_code[3] ? (pe_x - diff_x) : (pe_x + diff_x);

        // The sum fits OUT_W bits only when its top three bits agree.
        ovf = (sum[OUT_W+1:OUT_W-1] != 3'b000) && (sum[OUT_W+1:OUT_W-1] != 3'b111);
        new_pred = ovf ? {sum[OUT_W+1], {(OUT_W-1){~sum[OUT_W+1]}}} : sum[OUT_W-1:0];

        case (in_code[2:0])
            3'd4:    idx_adj = 8'sd2;
            3'd5:    idx_adj = 8'sd4;
            3'd6:    idx_adj = 8'sd6;
            3'd7:    idx_adj = 8'sd8;
            default: idx_adj = -8'sd1;
        endcase
        idx_sum = $signed({1'b0, ie}) + idx_adj;
        if (idx_sum < 8'sd0)       new_idx = 7'd0;
        else if (idx_sum > 8'sd88) new_idx = 7'd88;
        else                       new_idx = idx_sum[6:0];
    end

    // A header for a channel decoded in the same cycle was already folded into the decode.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                pred_q[i]  <= '0;
                index_q[i] <= '0;
            end
            out_valid  <= 1'b0;
            out_sample <= '0;
            out_ch     <= '0;
            out_eop    <= 1'b0;
        end else begin
            if (accept && ch_ok) begin
                pred_q[ch_sel]  <= new_pred;
                index_q[ch_sel] <= new_idx;
                out_valid       <= 1'b1;
                out_sample      <= new_pred;
                out_ch          <= in_ch;
                out_eop         <= in_eop;
            end else if (accept || out_ready) begin
                out_valid <= 1'b0;
            end
            if (hdr_valid && hdr_ok && !(accept && hdr_hit)) begin
                pred_q[hdr_ch]  <= hdr_pred_x;
                index_q[hdr_ch] <= hdr_idx_c;
            end
        end
    end

endmodule
